// File: rtl/posit_acc_seq_if.sv
// Stream, adder and result signals of the posit accumulator.
// POSIT_ACC_COUNT_EN adds the m_count result field.
interface posit_acc_seq_if #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned CNT_W     = 16
);
  logic [WORD_SIZE-1:0] s_data;
  logic                 s_last;
  logic                 s_valid;
  logic                 s_ready;
  logic [WORD_SIZE-1:0] add_in1;
  logic [WORD_SIZE-1:0] add_in2;
  logic [WORD_SIZE-1:0] add_out;
  logic                 add_inf;
  logic [WORD_SIZE-1:0] m_data;
  logic                 m_nar;
  logic                 m_zero;
  logic                 m_valid;
  logic                 m_ready;
`ifdef POSIT_ACC_COUNT_EN
  logic [CNT_W-1:0]     m_count;
`endif

  if (CNT_W == 0) begin : g_bad_cnt_w
    $error("CNT_W must be nonzero");
  end

  // Environment side: feeds elements, closes the adder loop, takes results.
  modport master (
    output s_data, s_last, s_valid, add_out, add_inf, m_ready,
    input  s_ready, add_in1, add_in2, m_data, m_nar, m_zero, m_valid
`ifdef POSIT_ACC_COUNT_EN
    , input m_count
`endif
  );

  // Accumulator side.
  modport slave (
    input  s_data, s_last, s_valid, add_out, add_inf, m_ready,
    output s_ready, add_in1, add_in2, m_data, m_nar, m_zero, m_valid
`ifdef POSIT_ACC_COUNT_EN
    , output m_count
`endif
  );
endinterface

// File: rtl/posit_acc_seq.sv
// Sequential reduction front-end for a combinational posit adder.
// Define POSIT_ACC_COUNT_EN to add the element counter and m_count output.
module posit_acc_seq #(
  parameter int unsigned WORD_SIZE = 32,
  parameter int unsigned ES        = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic           clk,
  input  logic           rst,
  posit_acc_seq_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StAccum = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StOut   = 2'd3;

  localparam logic [WORD_SIZE-1:0] NarPat = {1'b1, {(WORD_SIZE-1){1'b0}}};

  // A posit needs a sign bit, two regime bits and the exponent field.
  if (ES + 3 > WORD_SIZE || CNT_W == 0) begin : g_bad_params
    $error("posit_acc_seq: inconsistent WORD_SIZE/ES/CNT_W");
  end

  logic [1:0]           state_q, state_d;
  logic [WORD_SIZE-1:0] acc_q, acc_d;
  logic [WORD_SIZE-1:0] in1_q, in1_d;
  logic [WORD_SIZE-1:0] in2_q, in2_d;
  logic                 nar_q, nar_d;
  logic                 last_q, last_d;
  logic                 accept;
  logic                 in_out;

  assign bus.s_ready = (state_q == StIdle) || (state_q == StAccum);
  assign accept      = bus.s_valid & bus.s_ready;
  assign in_out      = (state_q == StOut);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    in1_d   = in1_q;
    in2_d   = in2_q;
    nar_d   = nar_q;
    last_d  = last_q;
    case (state_q)
      StIdle: begin
        // The first element seeds the accumulator without an adder pass.
        if (accept) begin
          acc_d   = bus.s_data;
          nar_d   = (bus.s_data == NarPat);
          state_d = bus.s_last ? StOut : StAccum;
        end
      end
      StAccum: begin
        if (accept) begin
          in1_d   = acc_q;
          in2_d   = bus.s_data;
          last_d  = bus.s_last;
          nar_d   = nar_q | (bus.s_data == NarPat);
          state_d = StWait;
        end
      end
      StWait: begin
        acc_d   = bus.add_out;
        nar_d   = nar_q | bus.add_inf;
        state_d = last_q ? StOut : StAccum;
      end
      StOut: begin
        if (bus.m_ready) begin
          nar_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      in1_q   <= '0;
      in2_q   <= '0;
      nar_q   <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      in1_q   <= in1_d;
      in2_q   <= in2_d;
      nar_q   <= nar_d;
      last_q  <= last_d;
    end
  end

`ifdef POSIT_ACC_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (accept) begin
      if (state_q == StIdle) begin
        cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else if (cnt_q != {CNT_W{1'b1}}) begin
        // Saturate rather than wrap on very long reductions.
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.m_count = cnt_q;
`endif

  assign bus.add_in1 = in1_q;
  assign bus.add_in2 = in2_q;
  assign bus.m_valid = in_out;
  assign bus.m_data  = in_out ? (nar_q ? NarPat : acc_q) : '0;
  assign bus.m_nar   = in_out & nar_q;
  assign bus.m_zero  = in_out & ~nar_q & (acc_q == '0);

endmodule

// File: tb/tb_posit_acc_seq.sv
// Directed bench for posit_acc_seq with a table-driven posit adder stand-in.
module tb_posit_acc_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  posit_acc_seq_if #(.WORD_SIZE(32), .CNT_W(16)) bus ();

  posit_acc_seq #(
    .WORD_SIZE(32),
    .ES(2),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Hand-computed posit<32,2> sums for the operand pairs this bench uses.
  function automatic logic [32:0] adder_model(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h8000_0000 || b == 32'h8000_0000) return {1'b1, 32'h8000_0000};
    if (a == 32'h0 && b == 32'h0) return {1'b0, 32'h0};
    case ({a, b})
      {32'h4000_0000, 32'h4000_0000}: return {1'b0, 32'h4800_0000};  // 1+1=2
      {32'h4000_0000, 32'hC000_0000}: return {1'b0, 32'h0000_0000};  // 1-1=0
      {32'h4800_0000, 32'h4000_0000}: return {1'b0, 32'h4C00_0000};  // 2+1=3
      {32'h4C00_0000, 32'h4000_0000}: return {1'b0, 32'h5000_0000};  // 3+1=4
      {32'h5000_0000, 32'h4000_0000}: return {1'b0, 32'h5200_0000};  // 4+1=5
      default:                        return {1'b0, 32'hDEAD_BEEF};
    endcase
  endfunction

  always_comb {bus.add_inf, bus.add_out} = adder_model(bus.add_in1, bus.add_in2);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic l);
    int n = 0;
    bus.s_data  = d;
    bus.s_last  = l;
    bus.s_valid = 1'b1;
    while (!bus.s_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.s_ready) check("push_timeout", 32'(bus.s_ready), 32'd1);
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  // Cycles from the cycle carrying the last element to the first m_valid cycle.
  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 1;
    while (!bus.m_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic take_result();
    bus.m_ready = 1'b1;
    @(negedge clk);
    bus.m_ready = 1'b0;
  endtask

  logic [31:0] held;

  initial begin
    rst         = 1'b1;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("rst_m_data", bus.m_data, 32'h0);
    check("rst_add_in1", bus.add_in1, 32'h0);
    check("rst_add_in2", bus.add_in2, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Single element passes straight through.
    push(32'h4000_0000, 1'b1);
    wait_valid("single", 1);
    check("single_data", bus.m_data, 32'h4000_0000);
    check("single_nar", 32'(bus.m_nar), 32'd0);
    check("single_zero", 32'(bus.m_zero), 32'd0);
    check("single_s_ready", 32'(bus.s_ready), 32'd0);
    take_result();
    check("single_done_valid", 32'(bus.m_valid), 32'd0);
    check("single_done_ready", 32'(bus.s_ready), 32'd1);

    // 1 + 1
    push(32'h4000_0000, 1'b0);
    push(32'h4000_0000, 1'b1);
    check("two_add_in1", bus.add_in1, 32'h4000_0000);
    check("two_add_in2", bus.add_in2, 32'h4000_0000);
    wait_valid("two", 2);
    check("two_data", bus.m_data, 32'h4800_0000);
    take_result();

    // 1 + (-1) cancels to zero.
    push(32'h4000_0000, 1'b0);
    push(32'hC000_0000, 1'b1);
    wait_valid("cancel", 2);
    check("cancel_data", bus.m_data, 32'h0);
    check("cancel_zero", 32'(bus.m_zero), 32'd1);
    check("cancel_nar", 32'(bus.m_nar), 32'd0);
    take_result();

    // NaR is sticky through later elements, and held under backpressure.
    push(32'h4000_0000, 1'b0);
    push(32'h8000_0000, 1'b0);
    push(32'h4000_0000, 1'b1);
    wait_valid("nar", 2);
    check("nar_data", bus.m_data, 32'h8000_0000);
    check("nar_flag", 32'(bus.m_nar), 32'd1);
    check("nar_zero", 32'(bus.m_zero), 32'd0);
    held = bus.m_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_data", bus.m_data, held);
      check("bp_valid", 32'(bus.m_valid), 32'd1);
      check("bp_s_ready", 32'(bus.s_ready), 32'd0);
    end
    take_result();
    push(32'h4000_0000, 1'b1);
    wait_valid("nar_clr", 1);
    check("nar_clr_flag", 32'(bus.m_nar), 32'd0);
    check("nar_clr_data", bus.m_data, 32'h4000_0000);
    take_result();

    // Reset in the middle of a reduction drops it.
    push(32'h4000_0000, 1'b0);
    push(32'h4000_0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_valid", 32'(bus.m_valid), 32'd0);
    check("mid_rst_s_ready", 32'(bus.s_ready), 32'd1);
    check("mid_rst_add_in1", bus.add_in1, 32'h0);
    check("mid_rst_add_in2", bus.add_in2, 32'h0);
    check("mid_rst_data", bus.m_data, 32'h0);
    check("mid_rst_nar", 32'(bus.m_nar), 32'd0);
    check("mid_rst_zero", 32'(bus.m_zero), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("mid_rst_quiet", 32'(bus.m_valid), 32'd0);
    end

    // Five ones sum to 5.
    for (int i = 0; i < 5; i++) push(32'h4000_0000, (i == 4));
    wait_valid("five", 2);
    check("five_data", bus.m_data, 32'h5200_0000);
`ifdef POSIT_ACC_COUNT_EN
    check("five_count", 32'(bus.m_count), 32'd5);
`endif
    take_result();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
